// File: rtl/scan_fault_seq_core_if.sv
// scan_fault_seq_core_if
// Purpose : bundles the functional, scan and fault-injection signals of
//           scan_fault_seq_core so the core and its driver share one port.
// Signals : A          - primary input per lane
//           se         - scan enable (1 = shift state chain, 0 = capture)
//           scan_in    - serial input of the state chain
//           scan_out   - serial output of the state chain (qC of last lane)
//           fault_load - shift the fault register by one bit this cycle
//           fault_in   - serial input of the fault register
//           K, B, C    - per-lane cone outputs (combinational)
//           shift_done - one-cycle pulse after every full chain load
// Modports: master drives the inputs of the core, slave is the core itself.
interface scan_fault_seq_core_if #(
  parameter int LANES = 4
);
  logic [LANES-1:0] A;
  logic             se;
  logic             scan_in;
  logic             scan_out;
  logic             fault_load;
  logic             fault_in;
  logic [LANES-1:0] K;
  logic [LANES-1:0] B;
  logic [LANES-1:0] C;
  logic             shift_done;

  modport master (
    output A, se, scan_in, fault_load, fault_in,
    input  K, B, C, scan_out, shift_done
  );

  modport slave (
    input  A, se, scan_in, fault_load, fault_in,
    output K, B, C, scan_out, shift_done
  );
endinterface

// File: rtl/scan_fault_seq_core.sv
// scan_fault_seq_core
// Purpose : LANES copies of the OR/AND/NOT/NOR cone with their qB/qC state
//           flops stitched into one scan chain, plus a serially loaded fault
//           register that injects a stuck-at fault on H or J of each lane.
// Ports   : clk - single clock, rising edge
//           rst - synchronous active-high reset
//           bus - scan_fault_seq_core_if.slave (see interface header)
module scan_fault_seq_core #(
  parameter int LANES = 4
) (
  input logic                  clk,
  input logic                  rst,
  scan_fault_seq_core_if.slave bus
);
  localparam int NB = 2 * LANES;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic {
    FUNC,
    SHIFT
  } state_t;

  // Chain bit 2i holds qB[i], bit 2i+1 holds qC[i]; shifting left walks
  // scan_in -> qB0 -> qC0 -> qB1 ... -> qC[LANES-1] -> scan_out.
  logic [NB-1:0]    r_chain;
  logic [NB-1:0]    r_fault;
  logic [NB-1:0]    w_capture;
  logic [LANES-1:0] w_h;
  logic [LANES-1:0] w_j;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_shift_done;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic       w_d;
    logic       w_h_raw;
    logic       w_j_raw;
    logic [1:0] w_mode;

    assign w_d     = r_chain[2*gi] | r_chain[2*gi+1];
    assign w_h_raw = bus.A[gi] & w_d;
    assign w_j_raw = ~w_d;
    assign w_mode  = r_fault[2*gi+1 : 2*gi];

    // 01: H stuck-at-0, 10: H stuck-at-1, 11: J stuck-at-1
    assign w_h[gi] = (w_mode == 2'b01) ? 1'b0 :
                     (w_mode == 2'b10) ? 1'b1 : w_h_raw;
    assign w_j[gi] = (w_mode == 2'b11) ? 1'b1 : w_j_raw;

    assign w_capture[2*gi]   = w_h[gi];
    assign w_capture[2*gi+1] = w_j[gi];
  end

  assign bus.B          = w_h;
  assign bus.C          = w_j;
  assign bus.K          = ~(w_h | w_j);
  assign bus.scan_out   = r_chain[NB-1];
  assign bus.shift_done = r_shift_done;

  // State chain and fault register; a fault load is independent of se.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
      r_fault <= '0;
    end else begin
      if (bus.se) begin
        r_chain <= {r_chain[NB-2:0], bus.scan_in};
      end else begin
        r_chain <= w_capture;
      end
      if (bus.fault_load) begin
        r_fault <= {r_fault[NB-2:0], bus.fault_in};
      end
    end
  end

  // Shift counter FSM. The counter holds the number of shifts already taken
  // in the current load, so the NB-th shift is the edge that sees NB-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FUNC;
      r_cnt        <= '0;
      r_shift_done <= 1'b0;
    end else begin
      r_shift_done <= 1'b0;
      case (r_state)
        FUNC: begin
          if (bus.se) begin
            r_state <= SHIFT;
            r_cnt   <= CW'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (!bus.se) begin
            r_state <= FUNC;
            r_cnt   <= '0;
          end else if (r_cnt == LAST) begin
            r_cnt        <= '0;
            r_shift_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= FUNC;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_scan_fault_seq_core.sv
// tb_scan_fault_seq_core
// Purpose : scoreboard bench for scan_fault_seq_core (LANES=4). The driver
//           pushes the expected outputs for every cycle into a queue from a
//           lane-level reference model; a monitor pops and compares them.
module tb_scan_fault_seq_core;
  localparam int L  = 4;
  localparam int NB = 2 * L;

  typedef struct packed {
    logic [L-1:0] k;
    logic [L-1:0] b;
    logic [L-1:0] c;
    logic         so;
    logic         sd;
  } exp_t;

  logic clk;
  logic rst;
  scan_fault_seq_core_if #(.LANES(L)) bus ();

  scan_fault_seq_core #(.LANES(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  exp_t sb[$];

  // Reference state: m_qb/m_qc per lane, fault register as a bit list
  // (m_f[0] is the newest bit), run length of the current se=1 stretch.
  logic m_qb[L];
  logic m_qc[L];
  logic m_f[NB];
  int   m_run;
  logic m_done;

  function automatic exp_t model_out(input logic [L-1:0] a);
    exp_t o;
    for (int i = 0; i < L; i++) begin
      logic d, h, j;
      int   mode;
      d    = m_qb[i] | m_qc[i];
      h    = a[i] & d;
      j    = !d;
      mode = 2 * int'(m_f[2*i+1]) + int'(m_f[2*i]);
      if (mode == 1) h = 1'b0;
      if (mode == 2) h = 1'b1;
      if (mode == 3) j = 1'b1;
      o.b[i] = h;
      o.c[i] = j;
      o.k[i] = !(h | j);
    end
    o.so = m_qc[L-1];
    o.sd = m_done;
    return o;
  endfunction

  task automatic model_edge(input logic r, input logic [L-1:0] a,
                            input logic s, input logic si,
                            input logic fl, input logic fi);
    exp_t o;
    logic chain[NB];
    o = model_out(a);
    if (r) begin
      for (int i = 0; i < L; i++) begin m_qb[i] = 0; m_qc[i] = 0; end
      for (int k = 0; k < NB; k++) m_f[k] = 0;
      m_run  = 0;
      m_done = 0;
      return;
    end
    if (s) begin
      // Flatten in chain order, shift by one toward scan_out, unflatten.
      for (int i = 0; i < L; i++) begin chain[2*i] = m_qb[i]; chain[2*i+1] = m_qc[i]; end
      for (int k = NB - 1; k > 0; k--) chain[k] = chain[k-1];
      chain[0] = si;
      for (int i = 0; i < L; i++) begin m_qb[i] = chain[2*i]; m_qc[i] = chain[2*i+1]; end
    end else begin
      for (int i = 0; i < L; i++) begin m_qb[i] = o.b[i]; m_qc[i] = o.c[i]; end
    end
    if (fl) begin
      for (int k = NB - 1; k > 0; k--) m_f[k] = m_f[k-1];
      m_f[0] = fi;
    end
    if (s) begin
      m_run  = m_run + 1;
      m_done = ((m_run % NB) == 0);
    end else begin
      m_run  = 0;
      m_done = 0;
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, then clock.
  task automatic step(input logic r, input logic [L-1:0] a, input logic s,
                      input logic si, input logic fl, input logic fi);
    rst            = r;
    bus.A          = a;
    bus.se         = s;
    bus.scan_in    = si;
    bus.fault_load = fl;
    bus.fault_in   = fi;
    sb.push_back(model_out(a));
    @(posedge clk);
    model_edge(r, a, s, si, fl, fi);
    #1;
  endtask

  task automatic check(input string name, input logic [L-1:0] act,
                       input logic [L-1:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %b, required %b", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("K", bus.K, e.k);
        check("B", bus.B, e.b);
        check("C", bus.C, e.c);
        check("scan_out", {3'b000, bus.scan_out}, {3'b000, e.so});
        check("shift_done", {3'b000, bus.shift_done}, {3'b000, e.sd});
      end
    end
  end

  initial begin
    logic [7:0] v;
    logic [7:0] fv;
    logic       se_cur;
    for (int i = 0; i < L; i++) begin m_qb[i] = 0; m_qc[i] = 0; end
    for (int k = 0; k < NB; k++) m_f[k] = 0;
    m_run  = 0;
    m_done = 0;

    rst = 1'b1; bus.A = '0; bus.se = 0; bus.scan_in = 0;
    bus.fault_load = 0; bus.fault_in = 0;
    @(posedge clk); #1;
    $display("[TB] reset cycle 2");
    step(1, 4'h0, 0, 0, 0, 0);

    $display("[TB] functional capture A=1111, then A=0000");
    step(0, 4'hF, 0, 0, 0, 0);
    step(0, 4'h0, 0, 0, 0, 0);

    $display("[TB] scan load 10110010 then flush with zeros");
    v = 8'b10110010;
    for (int k = 0; k < 8; k++) step(0, 4'($urandom), 1, v[7-k], 0, 0);
    for (int k = 0; k < 8; k++) step(0, 4'($urandom), 1, 0, 0, 0);
    step(0, 4'h0, 0, 0, 0, 0);

    $display("[TB] fault 01 on lane 0 with qB=1111");
    v  = 8'b01010101;
    fv = 8'b00000001;
    for (int k = 0; k < 8; k++) step(0, 4'hF, 1, v[7-k], 1, fv[7-k]);
    step(0, 4'hF, 0, 0, 0, 0);

    $display("[TB] fault 11 on lane 3 with qB=1111");
    fv = 8'b11000000;
    for (int k = 0; k < 8; k++) step(0, 4'hF, 1, v[7-k], 1, fv[7-k]);
    step(0, 4'hF, 0, 0, 0, 0);

    $display("[TB] reset mid-shift");
    for (int k = 0; k < 3; k++) step(0, 4'($urandom), 1, 1'($urandom), 0, 0);
    step(1, 4'hF, 1, 1, 1, 1);
    for (int k = 0; k < 8; k++) step(0, 4'($urandom), 1, 1'($urandom), 0, 0);
    step(0, 4'h0, 0, 0, 0, 0);

    $display("[TB] randomized traffic");
    se_cur = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) se_cur = ~se_cur;
      step(($urandom_range(0, 79) == 0), 4'($urandom), se_cur,
           1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom));
    end
    step(0, 4'h0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
